// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter feeding a single serial transmitter: grants one of four requesters,
// strobes the transmitter, then holds off new grants for the frame length plus a gap.
module serial_tx_arbiter #(
  parameter int unsigned FRAME_CYCLES = 10,
  parameter int unsigned GAP          = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_enable,
  input  logic [3:0]  i_req,
  input  logic [27:0] i_req_data,
  output logic [3:0]  o_ack,
  output logic        o_tx_start,
  output logic [6:0]  o_tx_data,
  output logic [1:0]  o_grant_id,
  output logic        o_busy,
  output logic        o_frame_done
);

  localparam int unsigned WaitLen = FRAME_CYCLES + GAP;
  localparam int unsigned CntW    = (WaitLen > 1) ? $clog2(WaitLen) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(WaitLen - 1);

  typedef enum logic [1:0] {StIdle, StStart, StWait} state_e;

  state_e          r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic [1:0]      r_last_grant;
  logic [1:0]      w_winner;
  logic [1:0]      w_idx;
  logic            w_found;
  logic            w_grant;
  logic [6:0]      w_slice;

  logic [3:0] r_ack;
  logic       r_tx_start;
  logic [6:0] r_tx_data;
  logic [1:0] r_grant_id;
  logic       r_busy;
  logic       r_frame_done;

  // Search begins one past the last winner, so the previous winner has lowest priority.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_last_grant;
    w_idx    = '0;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_last_grant + 2'(k);
      if (!w_found && i_req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  assign w_grant = (r_state == StIdle) && i_enable && w_found;
  assign w_slice = i_req_data[7*w_winner +: 7];

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_grant) w_state_d = StStart;
      end
      StStart: begin
        w_state_d = StWait;
        w_cnt_d   = CntLoad;
      end
      StWait: begin
        if (r_cnt == '0) w_state_d = StIdle;
        else             w_cnt_d   = r_cnt - 1'b1;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 2'd3;
      r_tx_data    <= '0;
      r_grant_id   <= '0;
      r_ack        <= '0;
      r_tx_start   <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_grant) begin
        r_last_grant <= w_winner;
        r_grant_id   <= w_winner;
        r_tx_data    <= w_slice;
      end
      r_tx_start   <= (w_state_d == StStart);
      r_ack        <= (w_state_d == StStart) ? (4'b0001 << w_winner) : 4'b0000;
      r_busy       <= (w_state_d != StIdle);
      r_frame_done <= (w_state_d == StWait) && (w_cnt_d == '0);
    end
  end

  assign o_ack        = r_ack;
  assign o_tx_start   = r_tx_start;
  assign o_tx_data    = r_tx_data;
  assign o_grant_id   = r_grant_id;
  assign o_busy       = r_busy;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Bench for serial_tx_arbiter: two instances (GAP=0 and GAP=3) share stimulus and are
// checked every cycle against a transaction-level model of grant timing.
module tb_serial_tx_arbiter;

  localparam int F = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  req = '0;
  logic [27:0] req_data = '0;

  logic [1:0][3:0] ack_v;
  logic [1:0]      tx_start_v;
  logic [1:0][6:0] tx_data_v;
  logic [1:0][1:0] gid_v;
  logic [1:0]      busy_v;
  logic [1:0]      fd_v;

  serial_tx_arbiter #(.FRAME_CYCLES(F), .GAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .i_enable(enable), .i_req(req), .i_req_data(req_data),
    .o_ack(ack_v[0]), .o_tx_start(tx_start_v[0]), .o_tx_data(tx_data_v[0]),
    .o_grant_id(gid_v[0]), .o_busy(busy_v[0]), .o_frame_done(fd_v[0])
  );

  serial_tx_arbiter #(.FRAME_CYCLES(F), .GAP(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .i_enable(enable), .i_req(req), .i_req_data(req_data),
    .o_ack(ack_v[1]), .o_tx_start(tx_start_v[1]), .o_tx_data(tx_data_v[1]),
    .o_grant_id(gid_v[1]), .o_busy(busy_v[1]), .o_frame_done(fd_v[1])
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  // Model: age = cycles since the grant edge (-1 when idle); frame spans ages 0..F+gap.
  int         gap_of [2] = '{0, 3};
  int         m_age  [2];
  int         m_last [2];
  logic [6:0] m_data [2];
  logic [1:0] m_gid  [2];
  int         t_start[2];

  int         q_start0[$];
  int         q_start3[$];
  logic [1:0] q_gid0[$];
  logic [6:0] q_data0[$];

  task automatic chk(input string tag, input int k, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_age[k]   = -1;
      m_last[k]  = 3;
      m_data[k]  = '0;
      m_gid[k]   = '0;
      t_start[k] = 0;
    end
  endtask

  task automatic model_edge(input int k);
    int fg;
    int w;
    bit found;
    fg = F + gap_of[k];
    if (m_age[k] >= 0) begin
      m_age[k]++;
      if (m_age[k] > fg) m_age[k] = -1;
    end else if (enable && req != 4'b0000) begin
      found = 1'b0;
      w = 0;
      for (int s = 1; s <= 4; s++) begin
        if (!found && req[(m_last[k] + s) % 4]) begin
          found = 1'b1;
          w = (m_last[k] + s) % 4;
        end
      end
      m_last[k] = w;
      m_gid[k]  = 2'(w);
      m_data[k] = req_data[7*w +: 7];
      m_age[k]  = 0;
    end
  endtask

  task automatic check_all(input int k);
    int fg;
    fg = F + gap_of[k];
    chk("tx_start", k, 32'(tx_start_v[k]), 32'(m_age[k] == 0));
    chk("ack", k, 32'(ack_v[k]), (m_age[k] == 0) ? 32'(4'b0001 << m_gid[k]) : 32'd0);
    chk("busy", k, 32'(busy_v[k]), 32'(m_age[k] >= 0));
    chk("frame_done", k, 32'(fd_v[k]), 32'(m_age[k] == fg));
    chk("tx_data", k, 32'(tx_data_v[k]), 32'(m_data[k]));
    chk("grant_id", k, 32'(gid_v[k]), 32'(m_gid[k]));
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge(0);
    model_edge(1);
    #1;
    for (int k = 0; k < 2; k++) begin
      check_all(k);
      if (tx_start_v[k]) t_start[k] = cyc;
      if (fd_v[k]) chk("done_offset", k, 32'(cyc - t_start[k]), 32'(F + gap_of[k]));
    end
    if (tx_start_v[0]) begin
      q_start0.push_back(cyc);
      q_gid0.push_back(gid_v[0]);
      q_data0.push_back(tx_data_v[0]);
    end
    if (tx_start_v[1]) q_start3.push_back(cyc);
  endtask

  // Asserted mid-cycle so the asynchronous clear is observed before any clock edge.
  task automatic apply_reset();
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(0);
    check_all(1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    req = '0;
    while (busy_v != 2'b00 && n < 60) begin
      tick();
      n++;
    end
    chk("idle_wait", 0, 32'(busy_v), 32'd0);
  endtask

  function automatic logic [9:0] tx_frame(input logic [6:0] d);
    return {1'b1, d, ^d, 1'b1};
  endfunction

  initial begin
    int busy_cnt0, busy_cnt3, starts, acks, n;
    bit saw_done;
    logic [9:0] frame_exp;

    model_reset();
    apply_reset();

    // Single request
    enable = 1'b1;
    req = 4'b0001;
    req_data[6:0] = 7'h55;
    tick();
    chk("single_start", 0, 32'(tx_start_v[0]), 32'd1);
    chk("single_ack", 0, 32'(ack_v[0]), 32'h1);
    chk("single_data", 0, 32'(tx_data_v[0]), 32'h55);
    req = '0;
    busy_cnt0 = 32'(busy_v[0]);
    busy_cnt3 = 32'(busy_v[1]);
    repeat (20) begin
      tick();
      busy_cnt0 += 32'(busy_v[0]);
      busy_cnt3 += 32'(busy_v[1]);
    end
    chk("single_busy_len", 0, 32'(busy_cnt0), 32'(F + 1));
    chk("single_busy_len", 1, 32'(busy_cnt3), 32'(F + 3 + 1));

    // Round-robin from reset with all requesters held
    apply_reset();
    q_start0.delete();
    q_start3.delete();
    q_gid0.delete();
    q_data0.delete();
    req_data = {7'h04, 7'h03, 7'h02, 7'h01};
    req = 4'b1111;
    n = 0;
    while (q_start0.size() < 5 && n < 100) begin
      tick();
      n++;
    end
    chk("rr_count", 0, 32'(q_start0.size()), 32'd5);
    if (q_start0.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        chk("rr_order", 0, 32'(q_gid0[i]), 32'(i % 4));
        chk("rr_data", 0, 32'(q_data0[i]), 32'((i % 4) + 1));
      end
      for (int i = 1; i < 5; i++)
        chk("rr_spacing", 0, 32'(q_start0[i] - q_start0[i-1]), 32'(F + 2));
    end
    chk("gap_count", 1, 32'(q_start3.size() >= 3), 32'd1);
    for (int i = 1; i < q_start3.size(); i++)
      chk("gap_spacing", 1, 32'(q_start3[i] - q_start3[i-1]), 32'(F + 3 + 2));
    wait_idle();

    // Enable gating: drop enable mid-frame with requester 1 pending
    enable = 1'b1;
    req = 4'b0100;
    tick();
    req = '0;
    repeat (3) tick();
    enable = 1'b0;
    req = 4'b0010;
    starts = 0;
    saw_done = 1'b0;
    n = 0;
    while ((busy_v != 2'b00 || n < 5) && n < 60) begin
      tick();
      starts += 32'(tx_start_v[0]);
      if (fd_v[0]) saw_done = 1'b1;
      n++;
    end
    chk("gate_done", 0, 32'(saw_done), 32'd1);
    chk("gate_no_start", 0, 32'(starts), 32'd0);
    enable = 1'b1;
    tick();
    chk("gate_start", 0, 32'(tx_start_v[0]), 32'd1);
    chk("gate_gid", 0, 32'(gid_v[0]), 32'd1);
    wait_idle();

    // Reset four cycles into WAIT
    req = 4'b0001;
    tick();
    req = '0;
    n = 0;
    while (m_age[0] != 4 && n < 10) begin
      tick();
      n++;
    end
    chk("mid_age", 0, 32'(m_age[0]), 32'd4);
    apply_reset();
    req = 4'b1000;
    tick();
    chk("post_rst_start", 0, 32'(tx_start_v[0]), 32'd1);
    chk("post_rst_gid", 0, 32'(gid_v[0]), 32'd3);
    wait_idle();

    // Payload captured at grant despite slice change during START
    req_data[20:14] = 7'h2A;
    req = 4'b0100;
    tick();
    req_data[20:14] = 7'h15;
    req = '0;
    acks = 32'(ack_v[0][2]);
    frame_exp = 10'b1010101011;
    chk("tx_frame", 0, 32'(tx_frame(tx_data_v[0])), 32'(frame_exp));
    repeat (15) begin
      tick();
      acks += 32'(ack_v[0][2]);
    end
    chk("capture_acks", 0, 32'(acks), 32'd1);
    chk("capture_data", 0, 32'(tx_data_v[0]), 32'h2A);
    wait_idle();

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      enable = ($urandom % 6) != 0;
      for (int i = 0; i < 4; i++) begin
        if (ack_v[0][i] && ($urandom % 2) == 0) req[i] = 1'b0;
        else if (!req[i] && ($urandom % 4) == 0) begin
          req[i] = 1'b1;
          req_data[7*i +: 7] = 7'($urandom);
        end
      end
      tick();
    end
    enable = 1'b1;
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
